// File: rtl/expr_eval_sequencer_if.sv
// Requester/response handshake bundle for expr_eval_sequencer.
// master: requesters plus response consumer; slave: the sequencer.
interface expr_eval_sequencer_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OPW  = 60,
  parameter int unsigned RESW = 90
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_ops;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_y;

  modport master (
    output req_valid, req_ops, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_ops, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/expr_eval_sequencer.sv
// Round-robin sequencer sharing one combinational expression unit among NREQ requesters.
// Optional result-signature MISR is built only when EXPR_SEQ_MISR_EN is defined.
module expr_eval_sequencer #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned OPW    = 60,
  parameter int unsigned RESW   = 90,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  expr_eval_sequencer_if.slave   bus,
  output logic [OPW-1:0]         dut_ops,
  input  logic [RESW-1:0]        dut_y,
  input  logic                   sig_clr,
  output logic [RESW-1:0]        sig
);
  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  gnt;
  logic            found;
  logic [3:0]      cnt;
  logic [IDW-1:0]  rsp_id_q;
  logic [RESW-1:0] rsp_y_q;
  logic            cap;

  // First requester at or after rr, wrapping.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr) + k) % NREQ;
      if (!found && bus.req_valid[IDW'(j)]) begin
        found = 1'b1;
        gnt   = IDW'(j);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && found) bus.req_ready[gnt] = 1'b1;
  end

  assign cap           = (state == DRIVE) && (cnt == '0);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= '0;
      dut_ops  <= '0;
      rsp_id_q <= '0;
      rsp_y_q  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            dut_ops  <= bus.req_ops[32'(gnt)*OPW +: OPW];
            rsp_id_q <= gnt;
            rr       <= (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            cnt      <= 4'(SETTLE - 1);
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (cap) begin
            rsp_y_q <= dut_y;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXPR_SEQ_MISR_EN
  // Rotate-left plus extra feedback of the top bit into bits 2, 3 and 5.
  localparam logic [RESW-1:0] TAPS = RESW'(6'b101100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (sig_clr) begin
      sig <= '0;
    end else if (cap) begin
      sig <= {sig[RESW-2:0], sig[RESW-1]} ^ dut_y ^ (sig[RESW-1] ? TAPS : '0);
    end
  end
`else
  logic unused_sig_clr;
  assign unused_sig_clr = sig_clr;
  assign sig = '0;
`endif
endmodule

// File: tb/tb_expr_eval_sequencer.sv
// Randomized self-checking bench for expr_eval_sequencer: SETTLE=1 instance under a
// transaction-level model, SETTLE=4 instance for settle-timing and reset-abort cases.
module tb_expr_eval_sequencer;
  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = 60;
  localparam int unsigned RESW = 90;
  localparam int SETTLE_A = 1;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  expr_eval_sequencer_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW)) bus_a ();
  expr_eval_sequencer_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW)) bus_b ();

  logic [OPW-1:0]  ops_a, ops_b;
  logic [RESW-1:0] y_a, y_b, sig_a, sig_b;
  logic            clr_a, clr_b;
  logic            ovr_a;
  logic [RESW-1:0] ovr_val_a;

  expr_eval_sequencer #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .SETTLE(SETTLE_A)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a), .dut_ops(ops_a), .dut_y(y_a),
    .sig_clr(clr_a), .sig(sig_a));

  expr_eval_sequencer #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .SETTLE(4)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b), .dut_ops(ops_b), .dut_y(y_b),
    .sig_clr(clr_b), .sig(sig_b));

  // Expression unit stand-in: product of the two 30-bit halves plus their XOR.
  function automatic logic [RESW-1:0] expr_f(input logic [OPW-1:0] o);
    logic [59:0] p;
    p = 60'(o[59:30]) * 60'(o[29:0]);
    return {p, o[29:0] ^ o[59:30]};
  endfunction

  assign y_a = ovr_a ? ovr_val_a : expr_f(ops_a);

  function automatic logic [RESW-1:0] misr_next(input logic [RESW-1:0] s, input logic [RESW-1:0] y);
    logic [RESW-1:0] r;
    r = (s << 1) ^ y;
    if (s[RESW-1]) r = r ^ RESW'(8'h2d);
    return r;
  endfunction

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [RESW-1:0] got, input logic [RESW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model for instance A: 0 idle, 1 operands held, 2 response pending.
  int              m_phase = 0;
  int              m_left  = 0;
  int              m_rr    = 0;
  int              m_id    = 0;
  logic [OPW-1:0]  m_ops   = '0;
  logic [RESW-1:0] m_y     = '0;
  logic [RESW-1:0] m_sig   = '0;

  logic [NREQ-1:0] rv;
  logic [OPW-1:0]  rops [NREQ];
  int              req_pct, drop_pct, rdy_pct, clr_pct;
  bit              hold_mode;
  logic [NREQ-1:0] en_mask;

  task automatic cycle_a();
    int g;
    int j;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!en_mask[i]) rv[i] = 1'b0;
      else if (!rv[i]) begin
        if ($urandom_range(99) < req_pct) begin
          rv[i]   = 1'b1;
          rops[i] = OPW'({$urandom(), $urandom()});
        end
      end else if (!hold_mode && $urandom_range(99) < drop_pct) rv[i] = 1'b0;
      bus_a.req_ops[i*OPW +: OPW] = rops[i];
    end
    bus_a.req_valid = rv;
    bus_a.rsp_ready = ($urandom_range(99) < rdy_pct);
    clr_a           = ($urandom_range(99) < clr_pct);
    #1;
    g = -1;
    exp_rdy = '0;
    if (m_phase == 0)
      for (int k = 0; k < NREQ; k++) begin
        j = (m_rr + k) % NREQ;
        if (g < 0 && rv[j]) g = j;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", RESW'(bus_a.req_ready), RESW'(exp_rdy));
    check("rsp_valid", RESW'(bus_a.rsp_valid), RESW'(m_phase == 2));
    if (m_phase == 2) begin
      check("rsp_id", RESW'(bus_a.rsp_id), RESW'(m_id));
      check("rsp_y", bus_a.rsp_y, m_y);
    end
    if (m_phase != 0) check("dut_ops", RESW'(ops_a), RESW'(m_ops));
    check("sig", sig_a, m_sig);
    case (m_phase)
      0: if (g >= 0) begin
        m_phase = 1;
        m_left  = SETTLE_A;
        m_id    = g;
        m_ops   = rops[g];
        m_rr    = (g + 1) % NREQ;
        if (hold_mode) rops[g] = OPW'({$urandom(), $urandom()});
        else rv[g] = 1'b0;
        if (clr_a) m_sig = '0;
      end else if (clr_a) m_sig = '0;
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_y = ovr_a ? ovr_val_a : expr_f(m_ops);
          m_phase = 2;
        end
        if (clr_a) m_sig = '0;
`ifdef EXPR_SEQ_MISR_EN
        else if (m_left == 0) m_sig = misr_next(m_sig, m_y);
`endif
      end
      default: begin
        if (bus_a.rsp_ready) m_phase = 0;
        if (clr_a) m_sig = '0;
      end
    endcase
  endtask

  task automatic run_a(input int n);
    for (int c = 0; c < n; c++) cycle_a();
  endtask

  initial begin
    logic [OPW-1:0]  opb;
    logic [RESW-1:0] ya, yb;
    rst_a = 1'b1; rst_b = 1'b1;
    rv = '0; en_mask = '0; hold_mode = 0;
    req_pct = 0; drop_pct = 0; rdy_pct = 100; clr_pct = 0;
    for (int i = 0; i < NREQ; i++) rops[i] = '0;
    ovr_a = 1'b0; ovr_val_a = '0; clr_a = 1'b0; clr_b = 1'b0;
    bus_a.req_valid = '1; bus_a.req_ops = '1; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = '1; bus_b.req_ops = '1; bus_b.rsp_ready = 1'b0;
    y_b = '0;
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #20;
    check("rst_req_ready_a", RESW'(bus_a.req_ready), '0);
    check("rst_rsp_valid_a", RESW'(bus_a.rsp_valid), '0);
    check("rst_rsp_id_a", RESW'(bus_a.rsp_id), '0);
    check("rst_rsp_y_a", bus_a.rsp_y, '0);
    check("rst_dut_ops_a", RESW'(ops_a), '0);
    check("rst_sig_a", sig_a, '0);
    check("rst_req_ready_b", RESW'(bus_b.req_ready), '0);
    bus_a.req_valid = '0; bus_b.req_valid = '0;
    @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;

    // Single requester 0 with forced result 1, then 2; signature cleared first.
    ovr_a = 1'b1; ovr_val_a = RESW'(1);
    en_mask = 4'b0001; req_pct = 100; clr_pct = 100;
    run_a(1);
    req_pct = 0; clr_pct = 0;
    run_a(4);
    ovr_val_a = RESW'(2); req_pct = 100;
    run_a(1);
    req_pct = 0;
    run_a(4);
    ovr_a = 1'b0;

    // All requesters held continuously, then a long response stall.
    en_mask = '1; hold_mode = 1; req_pct = 100;
    run_a(20);
    rdy_pct = 0;
    run_a(12);
    rdy_pct = 100;
    run_a(8);

    // Random traffic with drops, back-pressure and occasional signature clears.
    hold_mode = 0; req_pct = 30; drop_pct = 10; rdy_pct = 60; clr_pct = 5;
    run_a(2000);
    en_mask = '0; rdy_pct = 100; clr_pct = 0;
    run_a(10);

    // SETTLE=4: result changes from A to B two cycles after grant; B must be captured.
    opb = OPW'({$urandom(), $urandom()});
    ya = RESW'({$urandom(), $urandom(), $urandom()});
    yb = ~ya;
    @(negedge clk);
    bus_b.req_ops = '0; bus_b.req_ops[2*OPW +: OPW] = opb;
    bus_b.req_valid = 4'b0100; y_b = ya;
    #1 check("b_req_ready", RESW'(bus_b.req_ready), RESW'(4'b0100));
    @(posedge clk);
    @(negedge clk); bus_b.req_valid = '0;
    #1 check("b_drive_ready", RESW'(bus_b.req_ready), '0);
    check("b_dut_ops", RESW'(ops_b), RESW'(opb));
    @(posedge clk); @(posedge clk); #1 y_b = yb;
    @(negedge clk); check("b_valid_t2", RESW'(bus_b.rsp_valid), '0);
    @(negedge clk); check("b_valid_t3", RESW'(bus_b.rsp_valid), '0);
    @(negedge clk); check("b_valid_t4", RESW'(bus_b.rsp_valid), RESW'(1));
    check("b_rsp_y", bus_b.rsp_y, yb);
    check("b_rsp_id", RESW'(bus_b.rsp_id), RESW'(2));
    bus_b.rsp_ready = 1'b1;
    @(negedge clk); bus_b.rsp_ready = 1'b0;
    check("b_after_hs", RESW'(bus_b.rsp_valid), '0);

    // Reset during DRIVE: grant requester 0 (pointer then 1), abort, pointer back to 0.
    bus_b.req_valid = 4'b0001;
    @(negedge clk); bus_b.req_valid = 4'b0101;
    #1 check("b_drive_ready2", RESW'(bus_b.req_ready), '0);
    @(negedge clk); #2 rst_b = 1'b0;
    #1 check("b_rst_ops", RESW'(ops_b), '0);
    check("b_rst_valid", RESW'(bus_b.rsp_valid), '0);
    check("b_rst_id", RESW'(bus_b.rsp_id), '0);
    check("b_rst_y", bus_b.rsp_y, '0);
    check("b_rst_ready", RESW'(bus_b.req_ready), '0);
    check("b_rst_sig", sig_b, '0);
    @(negedge clk); rst_b = 1'b1;
    #1 check("b_rr_after_rst", RESW'(bus_b.req_ready), RESW'(4'b0001));
    bus_b.req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("b_no_rsp", RESW'(bus_b.rsp_valid), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/expr_eval_sequencer.md
# expr_eval_sequencer

Shares one combinational expression-evaluation unit (60-bit operand bundle in, 90-bit result out) between several requesters. Grants requests round-robin, drives the registered operand bundle into the unit, waits a fixed settle interval, captures the result and returns it, tagged with the requester id, over a valid/ready response channel. It sits between the regression stimulus sources and the expression datapath under test.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- OPW, 60, operand bundle width: {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, 30+30 bits
- RESW, 90, result width
- SETTLE, 1, cycles the operands are held before capture (1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_ops  in  NREQ*OPW  operand bundles; requester i at [i*OPW +: OPW]
- dut_ops  out  OPW  registered operands to the expression unit
- dut_y  in  RESW  combinational result from the expression unit
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NREQ)  id of the requester that owns rsp_y
- rsp_y  out  RESW  captured result
- sig_clr  in  1  synchronous clear of the signature
- sig  out  RESW  result signature (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE: the arbiter picks the first requester with req_valid set, scanning from pointer rr upward with wrap. req_ready[g] is high, combinationally, for that requester only. On that edge: dut_ops <= req_ops[g], id <= g, rr <= (g+1) mod NREQ, cnt <= SETTLE-1, go to DRIVE. With no request, stay in IDLE and keep dut_ops unchanged.
- DRIVE: when cnt==0, rsp_y <= dut_y and go to RESP. Otherwise decrement cnt.
- RESP: rsp_valid=1. rsp_y and rsp_id stay stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE. No new grant is made in the same cycle.
- req_ready is 0 in DRIVE and RESP. Only one transaction is in flight.
- A requester that drops req_valid before it is granted is not recorded.

## Timing
- Request accepted at edge T. dut_ops is valid from T. Capture happens at edge T+SETTLE. rsp_valid is high from T+SETTLE.
- Minimum request-to-response latency is SETTLE+1 cycles. Best-case throughput is one transaction per SETTLE+2 cycles (one IDLE cycle between transactions).
- Reset values: state=IDLE, rr=0, dut_ops=0, rsp_valid=0, rsp_id=0, rsp_y=0, sig=0, req_ready=0 while rst_n is low.
- Reset mid-operation aborts the in-flight transaction with no response. The pending requester must re-request.
- dut_y must settle within SETTLE cycles. The block does not check this.

## Configuration
- Macro EXPR_SEQ_MISR_EN.
- Defined: a RESW-bit MISR updates on every capture edge:
  - sig'[0] = sig[89]^y[0]
  - sig'[i] = sig[i-1]^y[i], with sig[89] also XORed in for i in {2,3,5}
  - sig_clr has priority over an update and sets sig to 0.
- Undefined: sig is tied to 0, sig_clr is ignored, no MISR flops are built.

## Test plan
- Single requester 0, SETTLE=1, dut_y looped to a model returning 90'h1 -> req_ready[0] at T, rsp_valid at T+1, rsp_id=0, rsp_y=1; the cycle after the handshake, IDLE with req_ready=0 for that cycle.
- All 4 requesters held valid continuously -> grant order 0,1,2,3,0; rsp_id sequence matches the grant order; rr wraps from 3 to 0.
- rsp_ready held low 10 cycles -> rsp_valid held, rsp_y/rsp_id unchanged, req_ready stays 0 for all requesters; release -> IDLE next cycle.
- SETTLE=4, dut_y changes at T+2 from A to B -> captured value B, rsp_valid at T+4.
- rst_n pulsed low during DRIVE -> all outputs zero asynchronously; no response issued; rr=0 after release.
- EXPR_SEQ_MISR_EN, sig_clr then captures of y=1 then y=2 -> sig=1, then 2^(1<<1)=0... expected sig=90'h0 after second. Without the macro, sig stays 0 throughout.
